// File: rtl/avalon_dmem_master.sv
// MEM-stage data-memory port: turns RISC-V loads/stores into Avalon-MM master cycles.
// Define DMEM_TIMEOUT_EN to enable the bus watchdog (bus_err after TIMEOUT_CYCLES).
module avalon_dmem_master #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [2:0]    funct3,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          misalign,
    output logic          bus_err,
    output logic          stall_req,
    output logic [AW-1:0] avm_address,
    output logic          avm_read,
    output logic          avm_write,
    output logic [31:0]   avm_writedata,
    output logic [3:0]    avm_byteenable,
    input  logic          avm_waitrequest,
    input  logic [31:0]   avm_readdata,
    input  logic          avm_readdatavalid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          write_q, write_d;
    logic          mis_q, mis_d;

    logic          req;
    size_t         in_size;
    logic [3:0]    in_be;
    logic [31:0]   in_wdata;
    logic          in_mis;
    logic [31:0]   byte_sh, half_sh, rd_ext;

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES + 1 > 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          berr_q, berr_d;
    logic          timeout;
`endif

    // Unlisted funct3 encodings behave as word accesses.
    function automatic size_t size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = SZ_B;
            3'b001, 3'b101: size_of = SZ_H;
            default:        size_of = SZ_W;
        endcase
    endfunction

    assign req = mem_read | mem_write;

    always_comb begin
        in_size  = size_of(funct3);
        in_be    = 4'b1111;
        in_wdata = wdata;
        in_mis   = 1'b0;
        case (in_size)
            SZ_B: begin
                in_be    = 4'b0001 << addr[1:0];
                in_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                in_be    = 4'b0011 << {addr[1], 1'b0};
                in_wdata = {2{wdata[15:0]}};
                in_mis   = addr[0];
            end
            default: in_mis = |addr[1:0];
        endcase
    end

    always_comb begin
        byte_sh = avm_readdata >> {addr_q[1:0], 3'b000};
        half_sh = avm_readdata >> {addr_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  rd_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  rd_ext = {24'h0, byte_sh[7:0]};
            3'b001:  rd_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  rd_ext = {16'h0, half_sh[15:0]};
            default: rd_ext = avm_readdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        mis_d    = mis_q;
        rdata_d  = rdata_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        berr_d   = berr_q;
        timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_TIMEOUT_EN
                cnt_d  = '0;
                berr_d = 1'b0;
`endif
                if (req) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    be_d     = in_be;
                    wdata_d  = in_wdata;
                    write_d  = mem_write;
                    mis_d    = in_mis;
                    state_d  = in_mis ? DONE : REQ;
                end
            end
            REQ: begin
`ifdef DMEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    state_d = DONE;
                    berr_d  = 1'b1;
                end
`endif
                // Acceptance on the watchdog's final cycle still counts as success.
                if (!avm_waitrequest) begin
                    state_d = write_q ? DONE : WAIT_RD;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d  = '0;
                    berr_d = 1'b0;
`endif
                end
            end
            WAIT_RD: begin
`ifdef DMEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    state_d = DONE;
                    berr_d  = 1'b1;
                end
`endif
                if (avm_readdatavalid) begin
                    rdata_d = rd_ext;
                    state_d = DONE;
`ifdef DMEM_TIMEOUT_EN
                    berr_d  = 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            mis_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= '0;
            berr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            berr_q   <= berr_d;
`endif
        end
    end

    assign done      = (state_q == DONE);
    assign misalign  = done & mis_q;
`ifdef DMEM_TIMEOUT_EN
    assign bus_err   = done & berr_q;
`else
    assign bus_err   = 1'b0;
`endif
    // Gated by RST so every output reads 0 while reset is held.
    assign stall_req = ~RST & (((state_q == IDLE) & req) | (state_q == REQ) | (state_q == WAIT_RD));
    assign avm_read       = (state_q == REQ) & ~write_q;
    assign avm_write      = (state_q == REQ) & write_q;
    assign avm_address    = {addr_q[AW-1:2], 2'b00};
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign rdata          = rdata_q;

endmodule

// File: tb/tb_avalon_dmem_master.sv
// Self-checking bench for avalon_dmem_master: directed plan items plus randomized
// transactions against a behavioural model of lanes, extension and cycle counts.
module tb_avalon_dmem_master;

    localparam int AW = 32;
`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        done, misalign, bus_err, stall_req;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] exp_rdata = '0;

    always #5 CLK = ~CLK;

    avalon_dmem_master #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .funct3(funct3),
        .rdata(rdata), .done(done), .misalign(misalign), .bus_err(bus_err),
        .stall_req(stall_req),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes-class: 0 byte, 1 half, 2 word.
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 0;
        if (f3 == 3'b001 || f3 == 3'b101) return 1;
        return 2;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
        case (m_size(f3))
            0:       return 4'(32'd1 << (a % 4));
            1:       return 4'(32'd3 << (a & 32'd2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] w, input logic [2:0] f3);
        case (m_size(f3))
            0:       return (w & 32'hFF) * 32'h01010101;
            1:       return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [2:0] f3);
        case (m_size(f3))
            0:       return 1'b0;
            1:       return (a % 2) != 0;
            default: return (a % 4) != 0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] v;
        case (m_size(f3))
            0: begin
                v = (w >> (8 * (a % 4))) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
            end
            1: begin
                v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic run_txn(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, input int nwait,
                           input int rlat, input logic [31:0] rdat, input bit junk, input bit exp_to);
        int          stall = 0, cmd = 0, cyc = 0, rv_at = -1, bad = 0;
        bit          seen = 1'b0;
        logic        mis_o = 1'b0, berr_o = 1'b0, stall_o = 1'b0;
        logic [31:0] rdata_o = '0;
        bit          emis = m_mis(a, f3);
        int          exp_stall, exp_cmd;

        @(posedge CLK); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
        avm_waitrequest = (nwait > 0);
        avm_readdatavalid = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge CLK);
            if (stall_req) stall++;
            if (avm_read || avm_write) begin
                if (avm_address !== (a & ~32'd3) || avm_byteenable !== m_be(a, f3) ||
                    (wr && avm_writedata !== m_wd(wd, f3)) || avm_write !== wr || avm_read !== !wr)
                    bad++;
                if (!avm_waitrequest && avm_read) rv_at = cyc + rlat;
                cmd++;
            end
            if (done) begin
                seen = 1'b1; mis_o = misalign; berr_o = bus_err; stall_o = stall_req; rdata_o = rdata;
            end
            @(posedge CLK); #1;
            cyc++;
            avm_waitrequest   = (cmd < nwait);
            avm_readdatavalid = (cyc == rv_at);
            avm_readdata      = (cyc == rv_at) ? rdat : $urandom;
            if (junk && avm_waitrequest && cmd > 0 && $urandom_range(0, 1) == 1) avm_readdatavalid = 1'b1;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;

        exp_stall = emis ? 1 : exp_to ? 1 + TO : wr ? nwait + 2 : nwait + 2 + rlat;
        exp_cmd   = emis ? 0 : exp_to ? TO : nwait + 1;
        if (!wr && !emis && !exp_to) exp_rdata = m_load(a, f3, rdat);

        check({nm, "/done_seen"}, 32'(seen), 32'd1);
        check({nm, "/stall_cycles"}, 32'(stall), 32'(exp_stall));
        check({nm, "/cmd_cycles"}, 32'(cmd), 32'(exp_cmd));
        check({nm, "/cmd_fields_bad"}, 32'(bad), 32'd0);
        check({nm, "/misalign"}, 32'(mis_o), 32'(emis));
        check({nm, "/bus_err"}, 32'(berr_o), 32'(exp_to));
        check({nm, "/stall_in_done"}, 32'(stall_o), 32'd0);
        check({nm, "/rdata"}, rdata_o, exp_rdata);
        @(negedge CLK);
        check({nm, "/done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "/flags"}, 32'({done, misalign, bus_err, stall_req, avm_read, avm_write}), 32'd0);
        check({nm, "/avm_address"}, avm_address, 32'd0);
        check({nm, "/avm_writedata"}, avm_writedata, 32'd0);
        check({nm, "/avm_byteenable"}, 32'(avm_byteenable), 32'd0);
        check({nm, "/rdata"}, rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        RST = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; funct3 = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("por");
        @(posedge CLK); #1;
        RST = 1'b0;

        // Signed byte load first so the mid-transaction reset has a nonzero rdata to clear.
        run_txn("lb41", 1, 0, 32'h41, 32'h0, 3'b000, 0, 1, 32'h0000F100, 0, 0);

        @(posedge CLK); #1;
        mem_read = 1'b1; addr = 32'h44; funct3 = 3'b010; avm_waitrequest = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_mid/avm_read_before", 32'(avm_read), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_all_zero("rst_mid");
        @(posedge CLK); #1;
        RST = 1'b0; mem_read = 1'b0; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h12345678;
        @(posedge CLK); #1;
        avm_readdatavalid = 1'b0;
        @(negedge CLK);
        exp_rdata = '0;
        check("rst_mid/late_rdv_rdata", rdata, 32'd0);
        check("rst_mid/stall_after", 32'(stall_req), 32'd0);

        run_txn("sw100", 0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 2, 1, 32'h0, 0, 0);
        run_txn("sb203", 0, 1, 32'h203, 32'h000000A5, 3'b000, 0, 1, 32'h0, 0, 0);
        run_txn("lbu41", 1, 0, 32'h41, 32'h0, 3'b100, 0, 1, 32'h0000F100, 0, 0);
        run_txn("lh42", 1, 0, 32'h42, 32'h0, 3'b001, 0, 1, 32'h80000000, 0, 0);
        run_txn("lw06_mis", 1, 0, 32'h06, 32'h0, 3'b010, 0, 1, 32'h0, 0, 0);
        run_txn("sh_mis", 0, 1, 32'h13, 32'h1234, 3'b001, 0, 1, 32'h0, 0, 0);
        run_txn("rw_both", 1, 1, 32'h22, 32'hCAFE, 3'b101, 1, 1, 32'h0, 0, 0);
        run_txn("lhu_wait", 1, 0, 32'h2E, 32'h0, 3'b101, 3, 3, 32'hBEEF0000, 1, 0);
        run_txn("f3_odd", 1, 0, 32'h30, 32'h0, 3'b111, 0, 2, 32'h89ABCDEF, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(1, 3);
            run_txn("rand", k[0], k[1], 32'($urandom_range(0, 255)), $urandom,
                    3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom, 1'($urandom_range(0, 1)), 0);
        end

`ifdef DMEM_TIMEOUT_EN
        run_txn("lw_timeout", 1, 0, 32'h80, 32'h0, 3'b010, 1000, 1, 32'h0, 0, 1);
        @(posedge CLK); #1;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h55AA55AA;
        @(posedge CLK); #1;
        avm_readdatavalid = 1'b0;
        @(negedge CLK);
        check("timeout/late_rdv_rdata", rdata, exp_rdata);
        check("timeout/stall_released", 32'(stall_req), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/avalon_dmem_master.md
Name: avalon_dmem_master

Overview:
- MEM-stage data-memory port of the pipelined RISC-V core. Converts load/store requests into Avalon-MM master transactions.
- Raises the data-memory stall request consumed by the hazard detection unit until the bus completes.
- Returns aligned, sign- or zero-extended load data to the MEM/WB register.

Parameters:
- AW, 32, byte address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- mem_read  in  1  MEM-stage load request.
- mem_write  in  1  MEM-stage store request.
- addr  in  AW  byte address.
- wdata  in  32  store data in the low bits.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  out  32  extended load data, held until the next load.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  one-cycle misaligned-access pulse.
- bus_err  out  1  one-cycle timeout pulse; tied 0 without the optional feature.
- stall_req  out  1  to the hazard unit's data-memory stall input.
- avm_address  out  AW  word-aligned address, {addr[AW-1:2],2'b00}.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  32  lane-replicated store data.
- avm_byteenable  out  4  byte lanes.
- avm_waitrequest  in  1  slave not accepting.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  pipelined read response.

Behaviour:
- Reset (RST high at a CLK edge, including mid-transaction):
  - state=IDLE.
  - All outputs 0, including rdata.
  - Any outstanding response is discarded.
- FSM states: IDLE, REQ, WAIT_RD, DONE.
- IDLE:
  - If mem_write, or mem_read without mem_write:
    - Latch address, byteenable, writedata, funct3 and op.
    - Go to REQ, or to DONE if misaligned.
  - Write wins if mem_read and mem_write are both high.
- REQ:
  - avm_read/avm_write, address, byteenable and writedata are driven from registers and held stable while avm_waitrequest=1.
  - When avm_waitrequest=0: a write goes to DONE; a read goes to WAIT_RD.
- WAIT_RD:
  - Command deasserted.
  - On avm_readdatavalid: capture the extracted lane into rdata, go to DONE.
  - avm_readdatavalid is ignored in every other state.
- DONE:
  - done=1 for one cycle, stall_req=0, inputs ignored (the same instruction is still presented).
  - Next state IDLE.
- stall_req (combinational) = (IDLE and request present) or REQ or WAIT_RD.
- Minimum latency with zero wait states:
  - Store: 2 stall cycles.
  - Load: 3 stall cycles (readdatavalid one cycle after acceptance).
- Byteenable:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Writedata replication:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes the word.
- Misaligned (H with addr[0]=1, or W with addr[1:0]!=0):
  - No bus cycle; IDLE->DONE.
  - misalign=1 and done=1 in DONE; rdata unchanged.
- funct3 values other than the five listed: treated as W.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ/WAIT_RD and increments each cycle in those states.
  - When count reaches TIMEOUT_CYCLES: deassert command, go to DONE with bus_err=1 and done=1; rdata unchanged.
  - A late readdatavalid is ignored.
- Undefined: no counter; bus_err constant 0; REQ/WAIT_RD wait indefinitely.

Test Plan:
- Reset: RST high for 2 cycles mid-REQ -> all outputs 0, state IDLE; a readdatavalid arriving afterwards does not update rdata.
- SW addr 0x100, wdata 0xDEADBEEF, waitrequest high 2 cycles -> avm_write high 3 cycles at address 0x100, byteenable 1111; stall_req high 4 cycles; done pulses once.
- SB addr 0x203, wdata 0x000000A5 -> address 0x200, byteenable 1000, writedata 0xA5A5A5A5.
- LB addr 0x41, readdata 0x0000F100 (byte 0xF1) -> rdata 0xFFFFFFF1; LBU same -> 0x000000F1; LH addr 0x42, readdata 0x80000000 -> 0xFFFF8000.
- LW addr 0x06 -> misalign and done pulse together; avm_read never asserted; stall_req high for 1 cycle.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, LW with waitrequest stuck high -> bus_err pulses after 8 cycles in REQ; avm_read drops; stall_req released.
